// File: rtl/seq_pkg.sv
// Shared definitions for the serial stream generator and the Mealy detector family.
// Both sides take the detected sequence from here so they cannot drift apart.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int                     SEQ_DET_LEN = 4;
    localparam logic [SEQ_DET_LEN-1:0] SEQ_DET_PAT = 4'b1101;

endpackage

// File: rtl/seq_ref_model.sv
// Golden Mealy detector: history of emitted bits, match flag aligned with x,
// and a saturating match counter cleared whenever a new stream starts.
module seq_ref_model #(
    parameter int                 DET_LEN = 4,
    parameter logic [DET_LEN-1:0] DET_PAT = 4'b1101,
    parameter int                 CNT_W   = 8
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             x,
    input  logic             x_valid,
    output logic             exp_y,
    output logic [CNT_W-1:0] match_count
);

    logic [DET_LEN-2:0] history;
    logic [DET_LEN-1:0] window;

    assign window = {history, x};
    assign exp_y  = x_valid && (window == DET_PAT);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            history     <= '0;
            match_count <= '0;
        end else if (x_valid) begin
            history <= window[DET_LEN-2:0];
            if (exp_y && (match_count != '1))
                match_count <= match_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_stream_gen.sv
// Parallel-load serial stream generator, MSB-first with repeat passes, feeding a
// Mealy sequence detector and carrying that detector's reference model.
//
// state | meaning
// IDLE  | waiting for start; load captures data/len/reps
// SHIFT | emitting one pattern bit per clock, passes back to back
// DONE  | one-cycle done pulse after the final bit
module seq_stream_gen
    import seq_pkg::*;
#(
    parameter int                 MAX_LEN = 16,
    parameter int                 LEN_W   = 5,
    parameter int                 REP_W   = 4,
    parameter int                 DET_LEN = SEQ_DET_LEN,
    parameter logic [DET_LEN-1:0] DET_PAT = SEQ_DET_PAT,
    parameter int                 CNT_W   = 8
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [MAX_LEN-1:0] data_in,
    input  logic [LEN_W-1:0]   len_in,
    input  logic [REP_W-1:0]   reps_in,
    input  logic               start,
    output logic               x,
    output logic               x_valid,
    output logic               busy,
    output logic               done,
    output logic               exp_y,
    output logic [CNT_W-1:0]   match_count
);

    state_t             state;
    logic [MAX_LEN-1:0] data_r;
    logic [LEN_W-1:0]   len_r;
    logic [REP_W-1:0]   reps_r;
    logic [LEN_W-1:0]   idx;
    logic [REP_W-1:0]   pass_left;

    logic [LEN_W-1:0]   len_clamp;
    logic [MAX_LEN-1:0] eff_data;
    logic [LEN_W-1:0]   eff_len;
    logic [REP_W-1:0]   eff_reps;
    logic               start_ok;

    // Explicit mux avoids an index wider than the pattern word.
    function automatic logic bit_at(input logic [MAX_LEN-1:0] d, input logic [LEN_W-1:0] i);
        logic b;
        b = 1'b0;
        for (int k = 0; k < MAX_LEN; k++)
            if (i == LEN_W'(k)) b = d[k];
        return b;
    endfunction

    assign len_clamp = (len_in > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_in;
    assign eff_data  = load ? data_in   : data_r;
    assign eff_len   = load ? len_clamp : len_r;
    assign eff_reps  = load ? reps_in   : reps_r;
    assign start_ok  = start && (state == IDLE);
    assign busy      = x_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            x         <= 1'b0;
            x_valid   <= 1'b0;
            done      <= 1'b0;
            data_r    <= '0;
            len_r     <= '0;
            reps_r    <= '0;
            idx       <= '0;
            pass_left <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (load) begin
                        data_r <= data_in;
                        len_r  <= len_clamp;
                        reps_r <= reps_in;
                    end
                    if (start) begin
                        if (eff_len != '0) begin
                            state     <= SHIFT;
                            x         <= bit_at(eff_data, eff_len - LEN_W'(1));
                            x_valid   <= 1'b1;
                            idx       <= eff_len - LEN_W'(1);
                            pass_left <= eff_reps;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (idx != '0) begin
                        idx <= idx - LEN_W'(1);
                        x   <= bit_at(data_r, idx - LEN_W'(1));
                    end else if (pass_left != '0) begin
                        pass_left <= pass_left - REP_W'(1);
                        idx       <= len_r - LEN_W'(1);
                        x         <= bit_at(data_r, len_r - LEN_W'(1));
                    end else begin
                        state   <= DONE;
                        x       <= 1'b0;
                        x_valid <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    seq_ref_model #(
        .DET_LEN (DET_LEN),
        .DET_PAT (DET_PAT),
        .CNT_W   (CNT_W)
    ) u_ref (
        .clk         (clk),
        .reset       (reset),
        .clear       (start_ok),
        .x           (x),
        .x_valid     (x_valid),
        .exp_y       (exp_y),
        .match_count (match_count)
    );

endmodule

// File: tb/tb_seq_stream_gen.sv
// Bench for seq_stream_gen: expected streams and matches are built from the
// pattern/length/repeat rules and compared cycle by cycle.
module tb_seq_stream_gen;

    logic        clk = 1'b0;
    logic        reset, load, start;
    logic [15:0] data_in;
    logic [4:0]  len_in;
    logic [3:0]  reps_in;

    logic        x, x_valid, busy, done, exp_y;
    logic [7:0]  match_count;
    logic        x2, x_valid2, busy2, done2, exp_y2;
    logic [1:0]  mc2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_stream_gen dut (
        .clk(clk), .reset(reset), .load(load), .data_in(data_in), .len_in(len_in),
        .reps_in(reps_in), .start(start), .x(x), .x_valid(x_valid), .busy(busy),
        .done(done), .exp_y(exp_y), .match_count(match_count)
    );

    // Narrow-counter copy sharing the same stimulus, for saturation.
    seq_stream_gen #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .load(load), .data_in(data_in), .len_in(len_in),
        .reps_in(reps_in), .start(start), .x(x2), .x_valid(x_valid2), .busy(busy2),
        .done(done2), .exp_y(exp_y2), .match_count(mc2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int n, input int m);
        return (n > m) ? m : n;
    endfunction

    // True when the DET_LEN bits ending at position k spell 1101 (bits before the stream read as 0).
    function automatic bit model_match(input bit s[$], input int k);
        logic [3:0] pat;
        int         p;
        bit         b;
        pat = 4'b1101;
        for (int j = 0; j < 4; j++) begin
            p = k - 3 + j;
            b = (p >= 0) ? s[p] : 1'b0;
            if (b != pat[3-j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Load+start a stream and follow it; optionally poke load/start or reset mid-stream.
    task automatic run_stream(input logic [15:0] d, input logic [4:0] l, input logic [3:0] r,
                              input int inject_at, input int reset_at, input string name);
        int leff, total, nmatch;
        bit s[$];
        bit ey;
        leff   = (l > 16) ? 16 : int'(l);
        total  = leff * (int'(r) + 1);
        nmatch = 0;
        for (int k = 0; k < total; k++) s.push_back(d[leff - 1 - (k % leff)]);

        load = 1'b1; start = 1'b1; data_in = d; len_in = l; reps_in = r;
        step();
        load = 1'b0; start = 1'b0; data_in = 16'($urandom); len_in = 5'($urandom); reps_in = 4'($urandom);

        if (total == 0) begin
            checks++;
            if (x_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
                errors++;
                $display("FAIL %s empty: x_valid=%b busy=%b done=%b required 0 0 1", name, x_valid, busy, done);
            end
            step();
            checks++;
            if (done !== 1'b0 || x_valid !== 1'b0 || match_count !== 8'd0) begin
                errors++;
                $display("FAIL %s empty_after: done=%b x_valid=%b count=%0d required 0 0 0", name, done, x_valid, match_count);
            end
            return;
        end

        for (int k = 0; k < total; k++) begin
            ey = model_match(s, k);
            checks++;
            if (x !== s[k] || x_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s bit%0d: x=%b x_valid=%b busy=%b done=%b required %b 1 1 0",
                         name, k, x, x_valid, busy, done, s[k]);
            end
            checks++;
            if (exp_y !== ey) begin
                errors++;
                $display("FAIL %s exp_y%0d: got %b required %b", name, k, exp_y, ey);
            end
            checks++;
            if (match_count !== 8'(sat(nmatch, 255)) || mc2 !== 2'(sat(nmatch, 3))) begin
                errors++;
                $display("FAIL %s count%0d: got %0d/%0d required %0d/%0d", name, k, match_count, mc2,
                         sat(nmatch, 255), sat(nmatch, 3));
            end
            if (ey) nmatch++;
            if (k == inject_at) begin
                load = 1'b1; start = 1'b1; data_in = ~d; len_in = 5'd5; reps_in = 4'd0;
            end
            if (k == reset_at) reset = 1'b1;
            step();
            load = 1'b0; start = 1'b0;
            if (k == reset_at) begin
                reset = 1'b0;
                checks++;
                if (x !== 1'b0 || x_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || match_count !== 8'd0) begin
                    errors++;
                    $display("FAIL %s reset: x=%b x_valid=%b busy=%b done=%b count=%0d required all 0",
                             name, x, x_valid, busy, done, match_count);
                end
                step();
                checks++;
                if (done !== 1'b0 || x_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s reset_nodone: done=%b x_valid=%b required 0 0", name, done, x_valid);
                end
                return;
            end
        end

        checks++;
        if (x !== 1'b0 || x_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL %s end: x=%b x_valid=%b busy=%b done=%b required 0 0 0 1", name, x, x_valid, busy, done);
        end
        checks++;
        if (match_count !== 8'(sat(nmatch, 255)) || mc2 !== 2'(sat(nmatch, 3))) begin
            errors++;
            $display("FAIL %s final_count: got %0d/%0d required %0d/%0d", name, match_count, mc2,
                     sat(nmatch, 255), sat(nmatch, 3));
        end
        step();
        checks++;
        if (done !== 1'b0 || x_valid !== 1'b0 || match_count !== 8'(sat(nmatch, 255))) begin
            errors++;
            $display("FAIL %s after_done: done=%b x_valid=%b count=%0d required 0 0 %0d", name, done, x_valid,
                     match_count, sat(nmatch, 255));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; start = 1'b0; data_in = '0; len_in = '0; reps_in = '0;
        step();
        step();
        reset = 1'b0;
        checks++;
        if (x !== 1'b0 || x_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || exp_y !== 1'b0 ||
            match_count !== 8'd0 || mc2 !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: x=%b x_valid=%b busy=%b done=%b exp_y=%b count=%0d required all 0",
                     x, x_valid, busy, done, exp_y, match_count);
        end
    endtask

    task automatic test_single_pass();
        run_stream(16'b0000011011011101, 5'd11, 4'd0, -1, -1, "single_pass");
        checks++;
        if (match_count !== 8'd3) begin
            errors++;
            $display("FAIL single_pass_total: got %0d required 3", match_count);
        end
    endtask

    task automatic test_repeat();
        run_stream(16'hAB0D, 5'd4, 4'd2, -1, -1, "repeat");
        checks++;
        if (match_count !== 8'd3) begin
            errors++;
            $display("FAIL repeat_total: got %0d required 3", match_count);
        end
    endtask

    task automatic test_zero_len();
        run_stream(16'hFFFF, 5'd0, 4'd3, -1, -1, "zero_len");
    endtask

    task automatic test_ignore_busy();
        run_stream(16'h1DB7, 5'd13, 4'd1, 4, -1, "ignore_busy");
    endtask

    task automatic test_mid_reset();
        run_stream(16'hDDDD, 5'd16, 4'd1, -1, 5, "mid_reset");
        // Loaded fields were zeroed, so a bare start behaves as an empty pattern.
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || x_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_start: done=%b x_valid=%b required 1 0", done, x_valid);
        end
        step();
    endtask

    task automatic test_saturate();
        run_stream(16'hDDDD, 5'd16, 4'd1, -1, -1, "saturate");
        checks++;
        if (mc2 !== 2'd3 || match_count !== 8'd8) begin
            errors++;
            $display("FAIL saturate_total: got %0d/%0d required 3/8", mc2, match_count);
        end
        run_stream(16'h0001, 5'd1, 4'd0, -1, -1, "restart_clear");
    endtask

    task automatic test_back_to_back_random();
        for (int i = 0; i < 14; i++)
            run_stream(16'($urandom), 5'($urandom_range(0, 20)), 4'($urandom_range(0, 3)), -1, -1, "random");
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_repeat();
        test_zero_len();
        test_ignore_busy();
        test_mid_reset();
        test_saturate();
        test_back_to_back_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
